multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles for the R-type, lw, sw, beq and bne instructions, plus optional j and addi. It drives the shared-ALU, single-memory datapath of the multi-cycle core and stalls on a memory-ready handshake. Illegal opcodes and memory timeouts are trapped deterministically; no output is ever x.

Parameters:
EN_JUMP, 1, decode j (6'b000010) when 1; treat it as illegal when 0
EN_ADDI, 1, decode addi (6'b001000) when 1; treat it as illegal when 0
WAIT_W, 8, width of the memory-wait counter
WAIT_MAX, 255, memory wait-cycle limit before a timeout trap; must be < 2**WAIT_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE onward
mem_ready  in  1  memory has completed the current read or write this cycle
PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, Ne  out  1 each  datapath controls
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
ALUSrcB  out  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left by 2
AluOP  out  2  00 add, 01 sub, 10 funct-decoded
state  out  4  current state, for debug
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal_op  out  1  sticky; set on entering TRAP from DECODE
mem_timeout  out  1  sticky; set on entering TRAP from a wait

Behaviour:
- Reset: when rst_n is 0 at a clk edge, the state goes to IDLE, the wait counter clears, and illegal_op, mem_timeout and the Ne latch clear. All outputs are 0 in IDLE.
- State encoding:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, TRAP=15
  - Encodings 13 and 14 go to TRAP.
- Outputs are a pure function of the state and mem_ready. Any control not listed for a state is 0.
- IDLE: always moves to FETCH on the next cycle.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOP=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Holds while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, AluOP=00.
  - Latches Ne = (opcode == 6'b000101).
  - Next state by opcode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 or 000101 -> BRANCH
    - 000010 -> JUMP (only when EN_JUMP=1)
    - 001000 -> ADDIEX (only when EN_ADDI=1)
    - any other opcode -> TRAP, with illegal_op set
- MEMADR: ALUSrcA=1, ALUSrcB=10, AluOP=00. Moves to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then moves to MEMWB.
- MEMWR: MemWrite=1, IorD=1. Waits for mem_ready, then moves to FETCH with instr_done=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Moves to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, AluOP=10. Moves to RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Moves to FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, AluOP=01, PCWriteCond=1, PCSource=01.
  - Ne output = latched Ne; Ne is 0 in every other state.
  - instr_done=1; moves to FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Moves to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, AluOP=00. Moves to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Moves to FETCH.
- Wait counter:
  - Increments on each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Clears on any state change.
  - If the count equals WAIT_MAX and mem_ready=0, the next state is TRAP and mem_timeout is set.
  - mem_ready=1 on that same cycle wins: normal transition, no trap.
- TRAP: all controls 0. Stays in TRAP until reset.
- Reset mid-instruction, including mid-wait: the cycle after the reset edge is IDLE, with no partial writes.
- Cycle counts with zero-wait memory (mem_ready held at 1):
  - R-type, addi: 4
  - lw: 5
  - sw: 4
  - beq, bne, j: 3

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state localparams
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI
  - AluOP codes ALU_ADD, ALU_SUB, ALU_FUNCT
  - ALUSrcB and PCSource select codes
- One sub-module, mc_wait_timer: the WAIT_W counter with clear, enable and expired outputs.

Test Plan:
- Reset, then R-type (opcode 000000), mem_ready=1 -> states 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in state 8; instr_done pulses once.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> holds in state 4 for 3 cycles with MemRead=1 and IorD=1, then 5 with MemtoReg=1 and RegWrite=1; 8 cycles from FETCH to instr_done.
- bne (000101) then beq (000100) -> in BRANCH, Ne=1 then Ne=0; PCWriteCond=1 and PCSource=01 both times.
- EN_JUMP=0, opcode 000010 -> DECODE goes to TRAP (15); illegal_op=1 and stays 1; all controls 0 until rst_n=0.
- WAIT_MAX=4, mem_ready=0 in FETCH -> TRAP after exactly 5 FETCH cycles with mem_timeout=1. Repeat with mem_ready=1 on the 5th cycle -> DECODE, no trap.
- rst_n=0 asserted during MEMWR -> next state IDLE; MemWrite=0 from that cycle on; the next cycle is FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   state_e        : FSM state encoding, also exported on the debug state port
//   OP_*           : instruction opcodes (IR[31:26]) understood by the decoder
//   ALU_*          : AluOP codes driven to the ALU control block
//   SRCB_*         : ALUSrcB mux selects
//   PCSRC_*        : PCSource mux selects
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12,
    ST_TRAP   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait counter for the multi-cycle control unit.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset, clears the count
//   clr      : clear the count (has priority over en)
//   en       : count one more wait cycle
//   expired  : count has reached WAIT_MAX
module mc_wait_timer
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_W   = 8,
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(WAIT_MAX);

  if (WAIT_MAX >= (2 ** WAIT_W)) begin : g_bad_wait_max
    $error("mc_wait_timer: WAIT_MAX must be below 2**WAIT_W");
  end

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == MAX_CNT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit (Moore FSM).
// Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq,
// bne and optionally j and addi, stalling on mem_ready. Illegal opcodes and
// memory waits longer than WAIT_MAX end in a sticky TRAP state.
//   clk, rst_n          : clock, synchronous active-low reset
//   opcode              : IR[31:26], stable from DECODE onward
//   mem_ready           : memory finished the current access this cycle
//   PCWrite .. Ne       : single-bit datapath controls
//   PCSource, ALUSrcB,
//   AluOP               : 2-bit datapath mux / ALU selects
//   state               : current FSM state (debug)
//   instr_done          : pulse on the last cycle of every instruction
//   illegal_op          : sticky, trapped on an undecodable opcode
//   mem_timeout         : sticky, trapped on a memory wait timeout
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter bit EN_JUMP  = 1'b1,
  parameter bit EN_ADDI  = 1'b1,
  parameter int WAIT_W   = 8,
  parameter int WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       Ne,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] AluOP,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  state_e state_q, state_d;
  logic   ne_q, ne_d;
  logic   illegal_q, illegal_d;
  logic   timeout_q, timeout_d;

  logic   wait_en;
  logic   wait_clr;
  logic   wait_expired;

  // Only the three memory-handshake states accumulate wait cycles.
  assign wait_en  = ((state_q == ST_FETCH) || (state_q == ST_MEMRD) ||
                     (state_q == ST_MEMWR)) && !mem_ready;
  assign wait_clr = (state_d != state_q);

  mc_wait_timer #(
    .WAIT_W   (WAIT_W),
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (wait_expired)
  );

  always_comb begin
    state_d   = state_q;
    ne_d      = ne_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        // A ready memory on the limit cycle still completes normally.
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end
      end
      ST_DECODE: begin
        ne_d = (opcode == OP_BNE);
        case (opcode)
          OP_RTYPE:       state_d = ST_EXEC;
          OP_LW, OP_SW:   state_d = ST_MEMADR;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_J: begin
            if (EN_JUMP) begin
              state_d = ST_JUMP;
            end else begin
              state_d   = ST_TRAP;
              illegal_d = 1'b1;
            end
          end
          OP_ADDI: begin
            if (EN_ADDI) begin
              state_d = ST_ADDIEX;
            end else begin
              state_d   = ST_TRAP;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: begin
        if (mem_ready) begin
          state_d = ST_MEMWB;
        end else if (wait_expired) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end
      end
      ST_MEMWR: begin
        if (mem_ready) begin
          state_d = ST_FETCH;
        end else if (wait_expired) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end
      end
      ST_MEMWB:  state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_RWB;
      ST_RWB:    state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ne_q      <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ne_q      <= ne_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    Ne          = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_B;
    AluOP       = ALU_ADD;
    instr_done  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // IR and PC+4 are captured only on the cycle the read completes.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_DECODE: ALUSrcB = SRCB_IMM_SH2;
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      ST_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        AluOP   = ALU_FUNCT;
      end
      ST_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        AluOP       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        Ne          = ne_q;
        instr_done  = 1'b1;
      end
      ST_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      ST_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ST_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Two instances share opcode/mem_ready:
// dut 0 has j and addi enabled, dut 1 has both disabled; both use WAIT_MAX=4.
// The instance not under test is held in reset.
module tb_multicycle_control;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5,
                         S_MEMWR = 4'd6, S_EXEC = 4'd7, S_RWB = 4'd8,
                         S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDIEX = 4'd11,
                         S_ADDIWB = 4'd12, S_TRAP = 4'd15;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_BNE = 6'b000101,
                         O_J = 6'b000010, O_ADDI = 6'b001000;

  localparam int WMAX = 4;

  typedef struct {
    logic [3:0] st;
    logic       mr;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n_a, rst_n_b, mem_ready;
  logic [5:0] opcode;
  logic       sel;

  logic [1:0] pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, ne, done, ill, mto;
  logic [1:0] pcsrc [2];
  logic [1:0] srcb  [2];
  logic [1:0] aluop [2];
  logic [3:0] st    [2];

  logic [3:0]  obs_state;
  logic [17:0] obs_ctrl;
  logic [1:0]  obs_flags;

  logic exp_ill, exp_to;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control #(.EN_JUMP(1'b1), .EN_ADDI(1'b1), .WAIT_W(8), .WAIT_MAX(WMAX)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .IorD(iord[0]), .MemRead(mrd[0]),
    .MemWrite(mwr[0]), .IRWrite(irw[0]), .MemtoReg(m2r[0]), .RegWrite(rw[0]),
    .RegDst(rdst[0]), .ALUSrcA(srca[0]), .Ne(ne[0]), .PCSource(pcsrc[0]),
    .ALUSrcB(srcb[0]), .AluOP(aluop[0]), .state(st[0]), .instr_done(done[0]),
    .illegal_op(ill[0]), .mem_timeout(mto[0])
  );

  multicycle_control #(.EN_JUMP(1'b0), .EN_ADDI(1'b0), .WAIT_W(8), .WAIT_MAX(WMAX)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .IorD(iord[1]), .MemRead(mrd[1]),
    .MemWrite(mwr[1]), .IRWrite(irw[1]), .MemtoReg(m2r[1]), .RegWrite(rw[1]),
    .RegDst(rdst[1]), .ALUSrcA(srca[1]), .Ne(ne[1]), .PCSource(pcsrc[1]),
    .ALUSrcB(srcb[1]), .AluOP(aluop[1]), .state(st[1]), .instr_done(done[1]),
    .illegal_op(ill[1]), .mem_timeout(mto[1])
  );

  always_comb begin
    obs_state = st[sel];
    obs_ctrl  = {pcw[sel], pcwc[sel], iord[sel], mrd[sel], mwr[sel], irw[sel],
                 m2r[sel], rw[sel], rdst[sel], srca[sel], ne[sel],
                 pcsrc[sel], srcb[sel], aluop[sel], done[sel]};
    obs_flags = {ill[sel], mto[sel]};
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Control word the specification lists for each state.
  function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic mr, input logic nel);
    logic e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rw, e_rd, e_sa, e_ne, e_dn;
    logic [1:0] e_ps, e_sb, e_ao;
    {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rw, e_rd, e_sa, e_ne, e_dn} = '0;
    e_ps = 2'b00; e_sb = 2'b00; e_ao = 2'b00;
    case (s)
      S_FETCH:  begin e_mrd = 1'b1; e_sb = 2'b01; e_irw = mr; e_pcw = mr; end
      S_DECODE: e_sb = 2'b11;
      S_MEMADR: begin e_sa = 1'b1; e_sb = 2'b10; end
      S_MEMRD:  begin e_mrd = 1'b1; e_iord = 1'b1; end
      S_MEMWR:  begin e_mwr = 1'b1; e_iord = 1'b1; e_dn = mr; end
      S_MEMWB:  begin e_m2r = 1'b1; e_rw = 1'b1; e_dn = 1'b1; end
      S_EXEC:   begin e_sa = 1'b1; e_ao = 2'b10; end
      S_RWB:    begin e_rd = 1'b1; e_rw = 1'b1; e_dn = 1'b1; end
      S_BRANCH: begin e_sa = 1'b1; e_ao = 2'b01; e_pcwc = 1'b1; e_ps = 2'b01;
                      e_ne = nel; e_dn = 1'b1; end
      S_JUMP:   begin e_pcw = 1'b1; e_ps = 2'b10; e_dn = 1'b1; end
      S_ADDIEX: begin e_sa = 1'b1; e_sb = 2'b10; end
      S_ADDIWB: begin e_rw = 1'b1; e_dn = 1'b1; end
      default: ;
    endcase
    return {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rw, e_rd, e_sa, e_ne,
            e_ps, e_sb, e_ao, e_dn};
  endfunction

  function automatic bit is_legal(input logic [5:0] opc, input bit en_j, input bit en_a);
    return (opc == O_R) || (opc == O_LW) || (opc == O_SW) || (opc == O_BEQ) ||
           (opc == O_BNE) || (en_j && opc == O_J) || (en_a && opc == O_ADDI);
  endfunction

  // One clock cycle: apply mem_ready, check the current state and outputs,
  // then advance to just after the next rising edge.
  task automatic cyc(input logic [3:0] es, input logic mr, input logic nel);
    logic [17:0] ec;
    mem_ready = mr;
    #1;
    ec = exp_ctrl(es, mr, nel);
    n_chk++;
    if (obs_state !== es) begin
      n_fail++;
      $display("FAIL state dut%0d t=%0t: got %0d expected %0d", sel, $time, obs_state, es);
    end
    n_chk++;
    if (obs_ctrl !== ec) begin
      n_fail++;
      $display("FAIL ctrl dut%0d t=%0t state %0d: got %b expected %b", sel, $time, es, obs_ctrl, ec);
    end
    n_chk++;
    if (obs_flags !== {exp_ill, exp_to}) begin
      n_fail++;
      $display("FAIL flags dut%0d t=%0t: got %b expected %b", sel, $time, obs_flags, {exp_ill, exp_to});
    end
    @(posedge clk);
    #1;
  endtask

  // Reset the selected instance for one edge; leaves it in FETCH.
  task automatic do_reset();
    if (sel) rst_n_b = 1'b0; else rst_n_a = 1'b0;
    opcode = 6'($urandom);
    @(posedge clk);
    #1;
    if (sel) rst_n_b = 1'b1; else rst_n_a = 1'b1;
    exp_ill = 1'b0;
    exp_to  = 1'b0;
    cyc(S_IDLE, rb(), 1'b0);
  endtask

  // Expected trace of one legal instruction starting in FETCH: wf not-ready
  // cycles in FETCH and wm not-ready cycles in the data memory access.
  task automatic run_instr(input logic [5:0] opc, input int wf, input int wm);
    step_t q[$];
    opcode = opc;
    for (int i = 0; i < wf; i++) q.push_back('{S_FETCH, 1'b0});
    q.push_back('{S_FETCH, 1'b1});
    q.push_back('{S_DECODE, rb()});
    case (opc)
      O_R: begin q.push_back('{S_EXEC, rb()}); q.push_back('{S_RWB, rb()}); end
      O_LW: begin
        q.push_back('{S_MEMADR, rb()});
        for (int i = 0; i < wm; i++) q.push_back('{S_MEMRD, 1'b0});
        q.push_back('{S_MEMRD, 1'b1});
        q.push_back('{S_MEMWB, rb()});
      end
      O_SW: begin
        q.push_back('{S_MEMADR, rb()});
        for (int i = 0; i < wm; i++) q.push_back('{S_MEMWR, 1'b0});
        q.push_back('{S_MEMWR, 1'b1});
      end
      O_BEQ, O_BNE: q.push_back('{S_BRANCH, rb()});
      O_J: q.push_back('{S_JUMP, rb()});
      O_ADDI: begin q.push_back('{S_ADDIEX, rb()}); q.push_back('{S_ADDIWB, rb()}); end
      default: ;
    endcase
    foreach (q[i]) cyc(q[i].st, q[i].mr, opc == O_BNE);
  endtask

  task automatic test_reset();
    sel = 1'b0; rst_n_a = 1'b0; rst_n_b = 1'b0; exp_ill = 1'b0; exp_to = 1'b0;
    opcode = 6'($urandom); mem_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(S_IDLE, rb(), 1'b0);
    rst_n_a = 1'b1;
    cyc(S_IDLE, rb(), 1'b0);
  endtask

  task automatic test_rtype();
    run_instr(O_R, 0, 0);
    run_instr(O_ADDI, 0, 0);
    run_instr(O_J, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr(O_LW, 0, 3);
    run_instr(O_SW, 2, 1);
    run_instr(O_SW, 0, 0);
  endtask

  task automatic test_branch();
    run_instr(O_BNE, 0, 0);
    run_instr(O_BEQ, 0, 0);
    run_instr(O_BNE, 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [7];
    ops = '{O_R, O_LW, O_SW, O_BEQ, O_BNE, O_J, O_ADDI};
    for (int k = 0; k < 60; k++) begin
      int wf, wm;
      wf = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, WMAX);
      wm = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, WMAX);
      run_instr(ops[$urandom_range(0, 6)], wf, wm);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i <= WMAX; i++) cyc(S_FETCH, 1'b0, 1'b0);
    exp_to = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = 6'($urandom);
      cyc(S_TRAP, rb(), 1'b0);
    end
    do_reset();
    run_instr(O_R, WMAX, 0);
    opcode = O_LW;
    cyc(S_FETCH, 1'b1, 1'b0);
    cyc(S_DECODE, rb(), 1'b0);
    cyc(S_MEMADR, rb(), 1'b0);
    for (int i = 0; i <= WMAX; i++) cyc(S_MEMRD, 1'b0, 1'b0);
    exp_to = 1'b1;
    cyc(S_TRAP, rb(), 1'b0);
    cyc(S_TRAP, rb(), 1'b0);
  endtask

  task automatic test_reset_mid_memwr();
    do_reset();
    opcode = O_SW;
    cyc(S_FETCH, 1'b1, 1'b0);
    cyc(S_DECODE, rb(), 1'b0);
    cyc(S_MEMADR, rb(), 1'b0);
    cyc(S_MEMWR, 1'b0, 1'b0);
    cyc(S_MEMWR, 1'b0, 1'b0);
    rst_n_a = 1'b0;
    cyc(S_MEMWR, 1'b0, 1'b0);
    rst_n_a = 1'b1;
    exp_to = 1'b0; exp_ill = 1'b0;
    cyc(S_IDLE, 1'b1, 1'b0);
    run_instr(O_LW, WMAX, WMAX);
  endtask

  task automatic test_illegal();
    logic [5:0] bad;
    do_reset();
    do bad = 6'($urandom); while (is_legal(bad, 1'b1, 1'b1));
    opcode = bad;
    cyc(S_FETCH, 1'b1, 1'b0);
    cyc(S_DECODE, rb(), 1'b0);
    exp_ill = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = 6'($urandom);
      cyc(S_TRAP, rb(), 1'b0);
    end
    rst_n_a = 1'b0;
    sel = 1'b1;
    do_reset();
    run_instr(O_R, 0, 0);
    opcode = O_J;
    cyc(S_FETCH, 1'b1, 1'b0);
    cyc(S_DECODE, rb(), 1'b0);
    exp_ill = 1'b1;
    for (int i = 0; i < 4; i++) cyc(S_TRAP, rb(), 1'b0);
    do_reset();
    opcode = O_ADDI;
    cyc(S_FETCH, 1'b1, 1'b0);
    cyc(S_DECODE, rb(), 1'b0);
    exp_ill = 1'b1;
    cyc(S_TRAP, rb(), 1'b0);
    cyc(S_TRAP, rb(), 1'b0);
    do_reset();
    run_instr(O_BNE, 1, 0);
    run_instr(O_LW, 0, 1);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_back_to_back();
    test_timeout();
    test_reset_mid_memwr();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
